// File: rtl/e_alu_arb.sv
// Round-robin arbiter sharing one combinational integer ALU between NUM_REQ issue ports,
// with a single valid/ready output register and a saturating contention counter.
module e_alu_arb #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 6,
  parameter int SRC_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*32-1:0]    req_r0_i,
  input  logic [NUM_REQ*32-1:0]    req_r1_i,
  input  logic [NUM_REQ*32-1:0]    req_pc_i,
  input  logic [NUM_REQ*3-1:0]     req_grand_op_i,
  input  logic [NUM_REQ*3-1:0]     req_op_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  output logic [31:0]              alu_r0_o,
  output logic [31:0]              alu_r1_o,
  output logic [31:0]              alu_pc_o,
  output logic [2:0]               alu_grand_op_o,
  output logic [2:0]               alu_op_o,
  input  logic [31:0]              alu_result_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_result_o,
  output logic [TAG_W-1:0]         out_tag_o,
  output logic [SRC_W-1:0]         out_src_o,
  output logic [31:0]              conflict_cnt_o
);

  logic [SRC_W-1:0] ptr_q;
  logic             out_valid_q;
  logic [31:0]      out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [SRC_W-1:0] out_src_q;
  logic [31:0]      cnt_q;

  logic [31:0]      r0_arr  [NUM_REQ];
  logic [31:0]      r1_arr  [NUM_REQ];
  logic [31:0]      pc_arr  [NUM_REQ];
  logic [2:0]       gop_arr [NUM_REQ];
  logic [2:0]       op_arr  [NUM_REQ];
  logic [TAG_W-1:0] tag_arr [NUM_REQ];

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               any_valid;
  logic               can_accept;
  logic               handshake;
  logic               conflict;
  logic [TAG_W-1:0]   sel_tag;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign r0_arr[gi]  = req_r0_i[32*gi +: 32];
      assign r1_arr[gi]  = req_r1_i[32*gi +: 32];
      assign pc_arr[gi]  = req_pc_i[32*gi +: 32];
      assign gop_arr[gi] = req_grand_op_i[3*gi +: 3];
      assign op_arr[gi]  = req_op_i[3*gi +: 3];
      assign tag_arr[gi] = req_tag_i[TAG_W*gi +: TAG_W];
      assign grant[gi]   = any_valid && (grant_idx == SRC_W'(gi));
    end
  endgenerate

  // Scan starts one past the last served requester and wraps, so priority only moves on a handshake.
  always_comb begin
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!any_valid && req_valid_i[idx]) begin
        any_valid = 1'b1;
        grant_idx = SRC_W'(idx);
      end
    end
  end

  // One-hot mux; an all-zero grant drives zeros onto the ALU.
  always_comb begin
    alu_r0_o       = '0;
    alu_r1_o       = '0;
    alu_pc_o       = '0;
    alu_grand_op_o = '0;
    alu_op_o       = '0;
    sel_tag        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_r0_o       = r0_arr[i];
        alu_r1_o       = r1_arr[i];
        alu_pc_o       = pc_arr[i];
        alu_grand_op_o = gop_arr[i];
        alu_op_o       = op_arr[i];
        sel_tag        = tag_arr[i];
      end
    end
  end

  always_comb begin
    int n;
    n = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n = n + int'(req_valid_i[i]);
    end
    conflict = (n >= 2);
  end

  assign can_accept  = rst_n && !flush_i && (!out_valid_q || out_ready_i);
  assign req_ready_o = can_accept ? grant : '0;
  assign handshake   = any_valid && can_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= SRC_W'(NUM_REQ - 1);
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_src_q    <= '0;
      cnt_q        <= '0;
    end else begin
      if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (handshake) begin
        out_valid_q  <= 1'b1;
        out_result_q <= alu_result_i;
        out_tag_q    <= sel_tag;
        out_src_q    <= grant_idx;
        ptr_q        <= grant_idx;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (conflict && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_result_o   = out_result_q;
  assign out_tag_o      = out_tag_q;
  assign out_src_o      = out_src_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_e_alu_arb.sv
// Bench for e_alu_arb: per-cycle reference model check plus directed literal expectations.
module tb_e_alu_arb;
  localparam int N  = 2;
  localparam int TW = 6;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b1;
  logic sat_load = 1'b0;

  logic [N-1:0]    v;
  logic [31:0]     r0 [N];
  logic [31:0]     r1 [N];
  logic [31:0]     pc [N];
  logic [2:0]      gop [N];
  logic [2:0]      op [N];
  logic [TW-1:0]   tag [N];

  logic [N-1:0]    req_ready;
  logic [N*32-1:0] p_r0, p_r1, p_pc;
  logic [N*3-1:0]  p_gop, p_op;
  logic [N*TW-1:0] p_tag;
  logic [31:0]     alu_r0, alu_r1, alu_pc, alu_result;
  logic [2:0]      alu_gop, alu_op;
  logic            out_valid;
  logic [31:0]     out_result, conflict_cnt;
  logic [TW-1:0]   out_tag;
  logic [SW-1:0]   out_src;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      p_r0[32*i +: 32]  = r0[i];
      p_r1[32*i +: 32]  = r1[i];
      p_pc[32*i +: 32]  = pc[i];
      p_gop[3*i +: 3]   = gop[i];
      p_op[3*i +: 3]    = op[i];
      p_tag[TW*i +: TW] = tag[i];
    end
  end

  // Reference ALU: grand op 1 is integer; anything else yields 0.
  function automatic logic [31:0] alu_fn(logic [2:0] g, logic [2:0] o, logic [31:0] a, logic [31:0] b);
    if (g != 3'd1) return 32'd0;
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_gop, alu_op, alu_r0, alu_r1);

  e_alu_arb #(.NUM_REQ(N), .TAG_W(TW), .SRC_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .req_valid_i(v), .req_ready_o(req_ready),
    .req_r0_i(p_r0), .req_r1_i(p_r1), .req_pc_i(p_pc),
    .req_grand_op_i(p_gop), .req_op_i(p_op), .req_tag_i(p_tag),
    .alu_r0_o(alu_r0), .alu_r1_o(alu_r1), .alu_pc_o(alu_pc),
    .alu_grand_op_o(alu_gop), .alu_op_o(alu_op), .alu_result_i(alu_result),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_result_o(out_result), .out_tag_o(out_tag), .out_src_o(out_src),
    .conflict_cnt_o(conflict_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: checks registered/combinational outputs each negedge, then advances state.
  int m_ptr = N - 1;
  logic m_valid = 1'b0;
  logic [31:0] m_result = '0, m_cnt = '0;
  logic [TW-1:0] m_tag = '0;
  int m_src = 0;

  always @(negedge clk) begin
    int g, pop;
    logic can;
    logic [N-1:0] exp_ready;
    if (!rst_n) begin
      m_ptr = N - 1; m_valid = 1'b0; m_result = '0; m_tag = '0; m_src = 0; m_cnt = '0;
      check("m_rst_ready", 32'(req_ready), 32'd0);
      check("m_rst_valid", 32'(out_valid), 32'd0);
      check("m_rst_cnt", conflict_cnt, 32'd0);
    end else begin
      if (sat_load) m_cnt = 32'hFFFF_FFFE;
      check("m_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("m_result", out_result, m_result);
        check("m_tag", 32'(out_tag), 32'(m_tag));
        check("m_src", 32'(out_src), 32'(m_src));
      end
      check("m_cnt", conflict_cnt, m_cnt);
      g = -1;
      pop = 0;
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      for (int i = 0; i < N; i++) pop += int'(v[i]);
      check("m_alu_r0", alu_r0, (g >= 0) ? r0[g] : 32'd0);
      check("m_alu_r1", alu_r1, (g >= 0) ? r1[g] : 32'd0);
      check("m_alu_pc", alu_pc, (g >= 0) ? pc[g] : 32'd0);
      check("m_alu_gop", 32'(alu_gop), (g >= 0) ? 32'(gop[g]) : 32'd0);
      check("m_alu_op", 32'(alu_op), (g >= 0) ? 32'(op[g]) : 32'd0);
      can = (!m_valid || out_ready) && !flush;
      exp_ready = (g >= 0 && can) ? N'(1 << g) : '0;
      check("m_ready", 32'(req_ready), 32'(exp_ready));
      if (flush) m_valid = 1'b0;
      else if (g >= 0 && can) begin
        m_valid = 1'b1;
        m_result = alu_fn(gop[g], op[g], r0[g], r1[g]);
        m_tag = tag[g];
        m_src = g;
        m_ptr = g;
      end else if (out_ready) m_valid = 1'b0;
      if (pop >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] o, input logic [TW-1:0] t);
    r0[i] = a; r1[i] = b; pc[i] = 32'h1000 + 32'(4 * i) + a; gop[i] = 3'd1; op[i] = o; tag[i] = t;
  endtask

  initial begin
    v = '0;
    for (int i = 0; i < N; i++) set_req(i, 32'd0, 32'd0, 3'd0, '0);
    step(); step();
    #1 rst_n = 1'b1;
    step();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_cnt", conflict_cnt, 32'd0);

    // single request on port 0
    set_req(0, 32'd5, 32'd3, 3'd0, TW'(7));
    v = 2'b01;
    #1 check("single_ready", 32'(req_ready), 32'b01);
    step();
    v = '0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_result", out_result, 32'd8);
    check("single_tag", 32'(out_tag), 32'd7);
    check("single_src", 32'(out_src), 32'd0);

    // one port-1 request moves the pointer so the alternation starts at 0
    set_req(1, 32'd1, 32'd1, 3'd4, TW'(2));
    v = 2'b10;
    step();
    v = '0;
    check("xor_result", out_result, 32'd0);
    step();
    check("pre_rr_cnt", conflict_cnt, 32'd0);

    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 32'(16 * i + c), 32'd1000, 3'd0, TW'(10 + i));
      v = 2'b11;
      step();
      check("rr_src", 32'(out_src), 32'(c % 2));
      check("rr_result", out_result, 32'(1000 + 16 * (c % 2) + c));
    end
    v = '0;
    check("rr_cnt", conflict_cnt, 32'd6);

    // backpressure: hold result 42 for three cycles with both ports waiting
    set_req(0, 32'd20, 32'd22, 3'd0, TW'(9));
    v = 2'b01;
    step();
    check("bp_first", out_result, 32'd42);
    out_ready = 1'b0;
    set_req(1, 32'd50, 32'd8, 3'd1, TW'(3));
    v = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_ready", 32'(req_ready), 32'd0);
      step();
      check("bp_hold", out_result, 32'd42);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'b10);
    step();
    v = '0;
    check("bp_result", out_result, 32'd42);
    check("bp_src", 32'(out_src), 32'd1);

    // flush with pending result under backpressure; pointer left at 0
    set_req(0, 32'd7, 32'd6, 3'd2, TW'(4));
    v = 2'b01;
    step();
    out_ready = 1'b0;
    flush = 1'b1;
    v = 2'b10;
    #1 check("flush_ready", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    v = 2'b11;
    #1 check("post_flush_ready", 32'(req_ready), 32'b10);
    step();
    v = '0;
    check("post_flush_src", 32'(out_src), 32'd1);

    // asynchronous reset with a valid result held
    v = 2'b01;
    step();
    v = '0;
    check("pre_arst_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_cnt", conflict_cnt, 32'd0);
    step();
    #1 rst_n = 1'b1;
    v = 2'b11;
    #1 check("arst_prio", 32'(req_ready), 32'b01);
    step();
    check("arst_src", 32'(out_src), 32'd0);

    // saturation of the contention counter
    sat_load = 1'b1;
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cnt_q;
    step();
    sat_load = 1'b0;
    check("sat_1", conflict_cnt, 32'hFFFF_FFFF);
    step();
    check("sat_2", conflict_cnt, 32'hFFFF_FFFF);
    step();
    check("sat_3", conflict_cnt, 32'hFFFF_FFFF);
    v = '0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e_alu_arb.md
Name: e_alu_arb

Overview:
- Round-robin arbiter and output pipeline stage that shares one combinational integer ALU between NUM_REQ issue ports.
- Each cycle it selects at most one valid request and drives that request's operands, pc and op codes to the ALU.
- It captures the ALU result, with its tag and source index, into a single output register using valid/ready flow control.
- It sits between the integer issue queues and the writeback/bypass network, and keeps a saturating contention counter for performance monitoring.

Parameters:
NUM_REQ, 2, number of requesters sharing the ALU (2..4)
TAG_W, 6, width of the per-request destination tag carried to writeback
SRC_W, 2, width of source-index field (must satisfy 2^SRC_W >= NUM_REQ)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush_i  input  1  pipeline flush; kills in-flight result, blocks acceptance this cycle
req_valid_i  input  NUM_REQ  per-requester request valid
req_ready_o  output  NUM_REQ  per-requester accept (one-hot or zero)
req_r0_i  input  NUM_REQ*32  operand 0, requester i at [32i+31:32i]
req_r1_i  input  NUM_REQ*32  operand 1, same packing
req_pc_i  input  NUM_REQ*32  pc, same packing
req_grand_op_i  input  NUM_REQ*3  grand op class, packed
req_op_i  input  NUM_REQ*3  sub-op, packed
req_tag_i  input  NUM_REQ*TAG_W  destination tag, packed
alu_r0_o  output  32  to ALU operand 0
alu_r1_o  output  32  to ALU operand 1
alu_pc_o  output  32  to ALU pc
alu_grand_op_o  output  3  to ALU grand op
alu_op_o  output  3  to ALU sub-op
alu_result_i  input  32  combinational ALU result for current alu_* drive
out_valid_o  output  1  registered result valid
out_ready_i  input  1  downstream accepts result
out_result_o  output  32  registered result
out_tag_o  output  TAG_W  tag of registered result
out_src_o  output  SRC_W  index of requester that produced result
conflict_cnt_o  output  32  saturating count of cycles with >=2 req_valid_i asserted

Behaviour:
- Reset (async, rst_n=0): out_valid_o=0, out_result_o=0, out_tag_o=0, out_src_o=0, conflict_cnt_o=0, rr pointer=NUM_REQ-1, so requester 0 has first priority. req_ready_o is 0 while in reset.
- can_accept = !out_valid_q | out_ready_i, and is forced 0 when flush_i=1.
- Grant selection (combinational):
  - Scan from (ptr+1) mod NUM_REQ upward, wrapping; the first i with req_valid_i[i]=1 is granted.
  - The grant depends only on valids and ptr, never on req_ready_o or out_ready_i.
- ALU drive:
  - alu_* carry the granted requester's fields whenever any valid exists, even if can_accept=0.
  - With no valid, all alu_* outputs are 0.
- req_ready_o[i] = grant[i] & can_accept; at most one bit is set. A handshake is req_valid_i[i] & req_ready_o[i].
- On handshake: next cycle out_valid_o=1, out_result_o=alu_result_i, out_tag_o=req_tag_i[i], out_src_o=i, and ptr=i. Latency is 1 cycle from request accept to output valid.
- No handshake and out_valid_q & out_ready_i: out_valid_o goes to 0. Data registers hold their value (don't care).
- out_valid_q & !out_ready_i: all output registers hold and req_ready_o=0 (backpressure). Back-to-back throughput of 1/cycle is required when out_ready_i stays 1.
- Flush:
  - flush_i=1 forces out_valid_o=0 next cycle, regardless of out_ready_i.
  - No request is accepted in the flush cycle and ptr does not change.
  - A result presented in the flush cycle is dropped even if out_ready_i=1; downstream must ignore it.
- ptr changes only on a handshake. Without handshakes, priority is stable and a waiting requester is never skipped.
- Contention counter: conflict_cnt_o increments by 1 each cycle in which popcount(req_valid_i)>=2, independent of flush and backpressure. It saturates at 32'hFFFF_FFFF and does not wrap.
- Fairness: with all NUM_REQ requesters continuously valid and no backpressure, grants rotate 0,1,...,NUM_REQ-1,0,... Any valid requester is served within NUM_REQ accepting cycles.
- Output data is not qualified by the ALU's grand_op; an unsupported op yields the ALU's value (0) as a normal result.

Test Plan:
- Reset then single request: req0 valid, r0=5, r1=3, grand_op=INT, op=ADD, tag=7 -> req_ready_o=01 same cycle; next cycle out_valid_o=1, out_result_o=8, out_tag_o=7, out_src_o=0.
- Both requesters continuously valid, out_ready_i=1, 6 cycles -> grants 0,1,0,1,0,1 and one result per cycle. conflict_cnt_o=6 after the 6 cycles.
- Backpressure: result valid with out_ready_i=0 for 3 cycles -> req_ready_o=00 and outputs held for all 3 cycles. When out_ready_i rises, the next request is accepted in that same cycle.
- Flush: result pending with out_ready_i=0, flush_i=1 one cycle while req1 valid -> req_ready_o=00 in that cycle, out_valid_o=0 next cycle, ptr unchanged. Afterwards req1 is accepted first if ptr=0.
- Asynchronous reset mid-stream: rst_n dropped between clock edges while out_valid_o=1 -> out_valid_o=0 and conflict_cnt_o=0 immediately, without waiting for a clock. After release, req0 has priority.
- Saturation: force conflict_cnt_o to 32'hFFFF_FFFE, 3 contention cycles -> reads FFFF_FFFF and stays there.
